axis_out_compactor: RTL

- Sits directly downstream of the engine's output width adapter, between it and the output DMA.
- Upstream beats carry a variable number of valid bytes, given by the bytes-per-transfer sideband. Valid bytes are always the lowest-addressed lanes.
- This block removes the gaps and repacks the stream into dense full-width beats, so the DMA writes contiguous memory.
- Packet boundaries (tlast) are preserved. Only the final beat of a packet may be partial.

---
 rtl/axis_out_compactor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axis_out_compactor.sv
// Repacks a sparse AXI-Stream (byte count carried in tuser) into dense full-width
// beats, preserving packet boundaries; only the last beat of a packet may be partial.
module axis_out_compactor #(
  parameter int DATA_WIDTH = 128,
  parameter int W_BPT      = 8,
  localparam int BYTES     = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [W_BPT-1:0]      s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BYTES-1:0]      m_axis_tkeep,
  output logic                  m_axis_tlast
);

  localparam int CW = $clog2(BYTES);
  localparam int NW = CW + 1;
  localparam int TW = CW + 2;
  localparam int AW = (BYTES - 1) * 8;
  localparam int XW = DATA_WIDTH + AW;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [BYTES-1:0]      m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;

  logic [NW-1:0]         n_eff;
  logic [BYTES-1:0]      in_mask;
  logic [DATA_WIDTH-1:0] in_bytes;
  logic [XW-1:0]         merged;
  logic [TW-1:0]         total;
  logic [CW-1:0]         rem;
  logic                  accept;
  logic                  out_taken;

  function automatic logic [BYTES-1:0] low_mask(input logic [TW-1:0] k);
    low_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      low_mask[i] = (TW'(i) < k);
    end
  endfunction

  assign s_axis_tready = aresetn && (state_q == RUN) && (!m_valid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_taken     = m_valid_q && m_axis_tready;

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;

  // Mask off bytes past the declared count, then splice them in right after the held bytes.
  always_comb begin
    n_eff    = (s_axis_tuser > W_BPT'(BYTES)) ? NW'(BYTES) : NW'(s_axis_tuser);
    in_mask  = low_mask(TW'(n_eff));
    in_bytes = '0;
    for (int i = 0; i < BYTES; i++) begin
      in_bytes[i*8 +: 8] = in_mask[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
    end
    merged = (XW'(in_bytes) << {cnt_q, 3'b000}) | XW'(acc_q);
    total  = TW'(cnt_q) + TW'(n_eff);
    rem    = CW'(total - TW'(BYTES));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;

    if (out_taken) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (accept) begin
          if (total < TW'(BYTES)) begin
            if (s_axis_tlast) begin
              m_valid_d = 1'b1;
              m_data_d  = merged[DATA_WIDTH-1:0];
              m_keep_d  = low_mask(total);
              m_last_d  = 1'b1;
              cnt_d     = '0;
              acc_d     = '0;
            end else begin
              cnt_d = CW'(total);
              acc_d = merged[AW-1:0];
            end
          end else if (total == TW'(BYTES)) begin
            m_valid_d = 1'b1;
            m_data_d  = merged[DATA_WIDTH-1:0];
            m_keep_d  = '1;
            m_last_d  = s_axis_tlast;
            cnt_d     = '0;
            acc_d     = '0;
          end else begin
            // Overflow: the remainder waits in acc, either for more input or for a flush beat.
            m_valid_d = 1'b1;
            m_data_d  = merged[DATA_WIDTH-1:0];
            m_keep_d  = '1;
            m_last_d  = 1'b0;
            cnt_d     = rem;
            acc_d     = merged[XW-1:DATA_WIDTH];
            if (s_axis_tlast) begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_taken) begin
          m_valid_d = 1'b1;
          m_data_d  = DATA_WIDTH'(acc_q);
          m_keep_d  = low_mask(TW'(cnt_q));
          m_last_d  = 1'b1;
          cnt_d     = '0;
          acc_d     = '0;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

endmodule
